// File: rtl/cpu_pkg.sv
// Shared definitions for the APB RAM model: transfer FSM state type and wait-counter width.
package cpu_pkg;

  typedef enum logic {StIdle, StAccess} apbram_state_t;

  localparam int unsigned ApbWaitW = 4;

endpackage

// File: rtl/apbram_array.sv
// DEPTH x 32 storage with a synchronous byte-enabled write port and a combinational read port.
// Contents are intentionally not reset.
module apbram_array #(
  parameter int unsigned Depth = 16384,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apbram.sv
// APB3/APB4 slave SRAM with independent read/write wait states and registered read data.
// Define APBRAM_PSLVERR_EN to enable range/privilege checking and the pslverr_o response.
module apbram
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned WIN_BYTES = 65536,
  parameter int unsigned RD_WAIT   = 0,
  parameter int unsigned WR_WAIT   = 0,
  parameter int unsigned PRIV_WR   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  input  logic [2:0]  pprot_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [31:0] OffMask  = 32'(WIN_BYTES - 1);
  localparam logic [31:0] RamBytes = 32'(DEPTH * 4);
  localparam logic [ApbWaitW-1:0] RdWaitC = RD_WAIT[ApbWaitW-1:0];
  localparam logic [ApbWaitW-1:0] WrWaitC = WR_WAIT[ApbWaitW-1:0];

  apbram_state_t       state_q;
  logic [ApbWaitW-1:0] cnt_q;
  logic [AddrW-1:0]    waddr_q;
  logic                write_q;
  logic [3:0]          strb_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [31:0]      offset;
  logic [AddrW-1:0] word_idx;
  logic [31:0]      ram_rdata;
  logic             setup;
  logic             access_ready;
  logic             complete;
  logic             req_err;
  logic             ram_we;

  assign offset       = paddr_i & OffMask;
  assign word_idx     = offset[AddrW+1:2];
  assign setup        = psel_i & ~penable_i;
  assign access_ready = (state_q == StAccess) && (cnt_q == '0);
  assign complete     = psel_i & penable_i & access_ready;
  assign ram_we       = complete & write_q & ~err_q;

`ifdef APBRAM_PSLVERR_EN
  assign req_err   = (offset >= RamBytes) | ((PRIV_WR != 0) & pwrite_i & ~pprot_i[0]);
  assign pslverr_o = access_ready & err_q;
`else
  // Without checking the window aliases modulo the RAM size and privilege is ignored.
  logic unused_nocheck;
  assign unused_nocheck = ^{offset, pprot_i, RamBytes, (PRIV_WR != 0)};
  assign req_err        = 1'b0;
  assign pslverr_o      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{offset[1:0], pprot_i[2:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      waddr_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (setup) begin
            state_q <= StAccess;
            cnt_q   <= pwrite_i ? WrWaitC : RdWaitC;
            waddr_q <= word_idx;
            write_q <= pwrite_i;
            strb_q  <= pstrb_i;
            err_q   <= req_err;
            // Address is held stable through the access phase, so sample the RAM now.
            rdata_q <= ram_rdata;
          end
        end
        StAccess: begin
          if (!psel_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (penable_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pready_o = access_ready;
  assign prdata_o = (access_ready & ~write_q & ~err_q) ? rdata_q : '0;

  apbram_array #(
    .Depth(DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(waddr_q),
    .wdata_i(pwdata_i),
    .wstrb_i(strb_q),
    .raddr_i(word_idx),
    .rdata_o(ram_rdata)
  );

endmodule
